iq_frame_feeder: RTL and testbench
==================================

# iq_frame_feeder

Framing front end for the I/Q peak searcher. It accepts a valid/ready stream of signed I/Q samples with a frame-last marker and counts N samples per frame. It drives the searcher's `data_en`/`data_i`/`data_q` inputs and pulses a clear before each new frame. It inserts a readout gap after every frame, and flags and recovers from malformed frame lengths.

## Interface
- `N`, 128: samples per frame (1..256).
- `DW`, 32: sample width per rail.
- `GAP_CYC`, 2: idle cycles after each frame, used for result readout (≥1).
- `clk` in 1: clock.
- `rstn` in 1: reset, asynchronous, active-low.
- `s_valid` in 1: input beat valid.
- `s_ready` out 1: input beat accepted when `s_valid && s_ready`.
- `s_i`, `s_q` in DW, signed: input sample.
- `s_last` in 1: marks the last beat of a frame.
- `data_en` out 1: output sample valid to the searcher.
- `data_i`, `data_q` out DW, signed: registered sample.
- `sample_idx` out 9: position of the output sample in its frame, 0..N-1.
- `frame_end` out 1: pulse with the final forwarded sample of a frame.
- `search_clr` out 1: one-cycle pulse; the searcher clears its max/index.
- `err_short` out 1: pulse; `s_last` arrived before N beats.
- `err_long` out 1: pulse; beat N had no `s_last`.
- `frame_cnt` out 16: completed frames, wraps at 65535→0.
- `busy` out 1: state ≠ IDLE.

## Operation
- States: IDLE, RUN, FLUSH, GAP.
- `s_ready` is decoded from state only:
  - 1 in IDLE, RUN, FLUSH.
  - 0 in GAP.
- Beat counter `cnt` (9 bit) holds the index of the next forwarded beat.
- IDLE, on an accepted beat: forward it with index 0.
  - N==1 or `s_last`: take the end-of-frame rules below.
  - Otherwise: go to RUN with `cnt`=1.
- RUN, on an accepted beat: forward it with index `cnt`, then `cnt`+1.
- End of frame, for the beat with index N-1:
  - `frame_end`=1 and `frame_cnt` increments.
  - With `s_last`: go to GAP.
  - Without `s_last`: `err_long`=1 and go to FLUSH.
- Short frame: `s_last` on a beat with index < N-1.
  - That beat is forwarded with `frame_end`=1 and `err_short`=1.
  - `frame_cnt` increments; go to GAP.
- FLUSH: accepted beats are dropped (no `data_en`). The accepted `s_last` beat goes to GAP.
- GAP: hold for GAP_CYC cycles, then go to IDLE.
  - `search_clr`=1 in the first IDLE cycle after GAP only.
  - A beat accepted in that same cycle is forwarded next cycle, after the clear.
- `err_short` and `err_long` are never both asserted for the same frame.
- Reset:
  - All outputs are 0, state IDLE, `cnt`=0.
  - No `search_clr` pulse on reset release; the searcher is reset by the same `rstn`.
  - Reset mid-frame discards the partial frame.

## Timing
- All outputs are registered except `s_ready`.
- Latency: an accepted beat in cycle t gives `data_en`=1 in t+1. `data_i`, `data_q`, `sample_idx`, `frame_end` and the err pulses are valid in the same cycle t+1.
- `data_en`=0 in every cycle without an accepted forwarded beat. Data outputs hold their last value.
- Throughput is 1 beat/cycle in RUN.
- Per-frame overhead is GAP_CYC cycles with `s_ready`=0, plus the clear cycle, which can accept a beat.
- The searcher's result is final in the cycle after `frame_end`. It stays stable through GAP until `search_clr`.

## Structure
- Package `iq_frame_pkg` holds:
  - the state enum;
  - default constants N_DEF=128, DW_DEF=32, GAP_DEF=2;
  - IDX_W=9.
- Single module; no sub-module. The counter and FSM are small enough to stay inline.

## Test plan
- Nominal frame: 128 contiguous beats (I=k, Q=-k), `s_last` on beat 128.
  - `data_en` 128 cycles, `sample_idx` 0..127, `frame_end` with idx 127.
  - No errors; `s_ready`=0 for 2 cycles, then `search_clr` one cycle; `frame_cnt`=1.
- Short frame: `s_last` on beat 50.
  - `frame_end` and `err_short` with idx 49.
  - GAP, then `search_clr`; the next frame starts at idx 0.
- Long frame: 130 beats, `s_last` on 130.
  - `err_long` with idx 127.
  - Beats 129–130 accepted but no `data_en`; then GAP and `search_clr`.
- Backpressure-free bubbles: `s_valid` toggling every other cycle over 128 beats.
  - `data_en` only on accepted beats, values and order preserved, idx contiguous 0..127.
- Reset mid-frame: `rstn` low at beat 60.
  - All outputs 0 and `s_ready`=1 after release, no `search_clr`.
  - The next frame indexes from 0 and `frame_cnt`=0.
- Back-to-back: 3 nominal frames with `s_valid` held high.
  - Exactly GAP_CYC stall cycles between frames; `frame_cnt`=3.
  - One `search_clr` per frame, each before that frame's first `data_en`.

Source files
------------

// File: rtl/iq_frame_pkg.sv
// Shared types and defaults for the I/Q frame feeder that sits in front of the peak searcher.
package iq_frame_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2,
        ST_GAP   = 2'd3
    } state_t;

    localparam int N_DEF   = 128;
    localparam int DW_DEF  = 32;
    localparam int GAP_DEF = 2;
    localparam int IDX_W   = 9;

endpackage

// File: rtl/iq_frame_feeder.sv
// Frames a valid/ready I/Q stream into N-sample blocks for the peak searcher,
// inserting a readout gap and a searcher clear between frames.
module iq_frame_feeder
    import iq_frame_pkg::*;
#(
    parameter int N       = N_DEF,
    parameter int DW      = DW_DEF,
    parameter int GAP_CYC = GAP_DEF
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 s_valid,
    output logic                 s_ready,
    input  logic signed [DW-1:0] s_i,
    input  logic signed [DW-1:0] s_q,
    input  logic                 s_last,
    output logic                 data_en,
    output logic signed [DW-1:0] data_i,
    output logic signed [DW-1:0] data_q,
    output logic [IDX_W-1:0]     sample_idx,
    output logic                 frame_end,
    output logic                 search_clr,
    output logic                 err_short,
    output logic                 err_long,
    output logic [15:0]          frame_cnt,
    output logic                 busy
);

    localparam int                GW       = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
    localparam logic [GW-1:0]     GAP_LOAD = GW'(GAP_CYC - 1);
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(N - 1);

    state_t                r_state;
    logic [IDX_W-1:0]      r_cnt;
    logic [GW-1:0]         r_gap;
    logic                  r_data_en;
    logic signed [DW-1:0]  r_data_i;
    logic signed [DW-1:0]  r_data_q;
    logic [IDX_W-1:0]      r_sample_idx;
    logic                  r_frame_end;
    logic                  r_search_clr;
    logic                  r_err_short;
    logic                  r_err_long;
    logic [15:0]           r_frame_cnt;
    logic                  r_busy;

    logic                  w_acc;
    logic                  w_at_end;

    assign s_ready  = (r_state != ST_GAP);
    assign w_acc    = s_valid && s_ready;
    // r_cnt is 0 whenever the FSM is idle, so it is the index of the next beat in IDLE and RUN.
    assign w_at_end = (r_cnt == LAST_IDX);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state      <= ST_IDLE;
            r_cnt        <= '0;
            r_gap        <= '0;
            r_data_en    <= 1'b0;
            r_data_i     <= '0;
            r_data_q     <= '0;
            r_sample_idx <= '0;
            r_frame_end  <= 1'b0;
            r_search_clr <= 1'b0;
            r_err_short  <= 1'b0;
            r_err_long   <= 1'b0;
            r_frame_cnt  <= '0;
            r_busy       <= 1'b0;
        end else begin
            r_data_en    <= 1'b0;
            r_frame_end  <= 1'b0;
            r_search_clr <= 1'b0;
            r_err_short  <= 1'b0;
            r_err_long   <= 1'b0;

            case (r_state)
                ST_IDLE, ST_RUN: begin
                    if (w_acc) begin
                        r_data_en    <= 1'b1;
                        r_data_i     <= s_i;
                        r_data_q     <= s_q;
                        r_sample_idx <= r_cnt;
                        r_busy       <= 1'b1;
                        if (w_at_end || s_last) begin
                            r_frame_end <= 1'b1;
                            r_frame_cnt <= r_frame_cnt + 16'd1;
                            r_cnt       <= '0;
                            if (s_last) begin
                                r_err_short <= !w_at_end;
                                r_gap       <= GAP_LOAD;
                                r_state     <= ST_GAP;
                            end else begin
                                r_err_long  <= 1'b1;
                                r_state     <= ST_FLUSH;
                            end
                        end else begin
                            r_cnt   <= r_cnt + IDX_W'(1);
                            r_state <= ST_RUN;
                        end
                    end
                end
                // Overlong frame: swallow beats until the sender finally marks the end.
                ST_FLUSH: begin
                    if (w_acc && s_last) begin
                        r_gap   <= GAP_LOAD;
                        r_state <= ST_GAP;
                    end
                end
                ST_GAP: begin
                    if (r_gap == '0) begin
                        r_state      <= ST_IDLE;
                        r_busy       <= 1'b0;
                        r_search_clr <= 1'b1;
                    end else begin
                        r_gap <= r_gap - GW'(1);
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign data_en    = r_data_en;
    assign data_i     = r_data_i;
    assign data_q     = r_data_q;
    assign sample_idx = r_sample_idx;
    assign frame_end  = r_frame_end;
    assign search_clr = r_search_clr;
    assign err_short  = r_err_short;
    assign err_long   = r_err_long;
    assign frame_cnt  = r_frame_cnt;
    assign busy       = r_busy;

endmodule

// File: tb/tb_iq_frame_feeder.sv
// Directed bench for iq_frame_feeder: nominal, short, long, bubbled, reset and back-to-back frames.
module tb_iq_frame_feeder;

    logic               clk = 1'b0;
    logic               rstn;
    logic               s_valid;
    logic               s_ready;
    logic signed [31:0] s_i;
    logic signed [31:0] s_q;
    logic               s_last;
    logic               data_en;
    logic signed [31:0] data_i;
    logic signed [31:0] data_q;
    logic [8:0]         sample_idx;
    logic               frame_end;
    logic               search_clr;
    logic               err_short;
    logic               err_long;
    logic [15:0]        frame_cnt;
    logic               busy;

    int n_assert = 0;
    int n_fail   = 0;

    iq_frame_feeder #(.N(128), .DW(32), .GAP_CYC(2)) dut (
        .clk        (clk),
        .rstn       (rstn),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .s_i        (s_i),
        .s_q        (s_q),
        .s_last     (s_last),
        .data_en    (data_en),
        .data_i     (data_i),
        .data_q     (data_q),
        .sample_idx (sample_idx),
        .frame_end  (frame_end),
        .search_clr (search_clr),
        .err_short  (err_short),
        .err_long   (err_long),
        .frame_cnt  (frame_cnt),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input int k, input logic last);
        s_valid = v;
        s_i     = k;
        s_q     = -k;
        s_last  = last;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_beat(input string tag, input int k, input logic fe, input logic es, input logic el);
        chk({tag, " data_en"},    {31'd0, data_en},    32'd1);
        chk({tag, " data_i"},     data_i,              k);
        chk({tag, " data_q"},     data_q,              -k);
        chk({tag, " sample_idx"}, {23'd0, sample_idx}, k);
        chk({tag, " frame_end"},  {31'd0, frame_end},  {31'd0, fe});
        chk({tag, " err_short"},  {31'd0, err_short},  {31'd0, es});
        chk({tag, " err_long"},   {31'd0, err_long},   {31'd0, el});
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, " data_en"},    {31'd0, data_en},    32'd0);
        chk({tag, " data_i"},     data_i,              32'd0);
        chk({tag, " data_q"},     data_q,              32'd0);
        chk({tag, " sample_idx"}, {23'd0, sample_idx}, 32'd0);
        chk({tag, " frame_end"},  {31'd0, frame_end},  32'd0);
        chk({tag, " search_clr"}, {31'd0, search_clr}, 32'd0);
        chk({tag, " err_short"},  {31'd0, err_short},  32'd0);
        chk({tag, " err_long"},   {31'd0, err_long},   32'd0);
        chk({tag, " frame_cnt"},  {16'd0, frame_cnt},  32'd0);
        chk({tag, " busy"},       {31'd0, busy},       32'd0);
        chk({tag, " s_ready"},    {31'd0, s_ready},    32'd1);
    endtask

    // Starting just after a frame's last beat: two stalled cycles, then the clear cycle.
    task automatic chk_gap(input string tag);
        chk({tag, " gap0 s_ready"}, {31'd0, s_ready}, 32'd0);
        drive(1'b0, 0, 1'b0);
        tick();
        chk({tag, " gap1 s_ready"}, {31'd0, s_ready}, 32'd0);
        chk({tag, " gap1 data_en"}, {31'd0, data_en}, 32'd0);
        chk({tag, " gap1 clr"},     {31'd0, search_clr}, 32'd0);
        tick();
        chk({tag, " clr s_ready"},  {31'd0, s_ready}, 32'd1);
        chk({tag, " clr pulse"},    {31'd0, search_clr}, 32'd1);
        chk({tag, " clr busy"},     {31'd0, busy}, 32'd0);
        $display("%s: gap of 2 stall cycles then search_clr", tag);
    endtask

    initial begin
        int stalls;
        rstn = 1'b0;
        drive(1'b0, 0, 1'b0);
        tick();
        tick();
        chk_all_zero("reset");
        rstn = 1'b1;
        tick();
        chk("post-reset clr", {31'd0, search_clr}, 32'd0);
        $display("reset: outputs cleared, s_ready=%0b", s_ready);

        // Nominal 128-beat frame
        for (int k = 0; k < 128; k++) begin
            drive(1'b1, k, k == 127);
            tick();
            chk_beat("nominal", k, k == 127, 1'b0, 1'b0);
        end
        chk("nominal frame_cnt", {16'd0, frame_cnt}, 32'd1);
        chk("nominal busy",      {31'd0, busy},      32'd1);
        $display("nominal: 128 beats, frame_cnt=%0d", frame_cnt);
        chk_gap("nominal");

        // Short frame: s_last on beat 50 (index 49)
        for (int k = 0; k < 50; k++) begin
            drive(1'b1, k, k == 49);
            tick();
            chk_beat("short", k, k == 49, k == 49, 1'b0);
        end
        chk("short frame_cnt", {16'd0, frame_cnt}, 32'd2);
        $display("short: err_short at idx %0d", sample_idx);
        chk_gap("short");

        // Long frame: 130 beats, the last two dropped
        for (int k = 0; k < 128; k++) begin
            drive(1'b1, k, 1'b0);
            tick();
            chk_beat("long", k, k == 127, 1'b0, k == 127);
        end
        chk("long frame_cnt", {16'd0, frame_cnt}, 32'd3);
        drive(1'b1, 128, 1'b0);
        tick();
        chk("long beat129 data_en", {31'd0, data_en}, 32'd0);
        chk("long beat129 s_ready", {31'd0, s_ready}, 32'd1);
        chk("long beat129 err_long", {31'd0, err_long}, 32'd0);
        drive(1'b1, 129, 1'b1);
        tick();
        chk("long beat130 data_en", {31'd0, data_en}, 32'd0);
        chk("long hold data_i",     data_i, 32'd127);
        $display("long: err_long at idx 127, beats 129-130 dropped");
        chk_gap("long");

        // Bubbles: a beat every other cycle
        for (int k = 0; k < 128; k++) begin
            drive(1'b1, k, k == 127);
            tick();
            chk_beat("bubble", k, k == 127, 1'b0, 1'b0);
            if (k != 127) begin
                drive(1'b0, 1000, 1'b0);
                tick();
                chk("bubble idle data_en", {31'd0, data_en}, 32'd0);
                chk("bubble hold data_i",  data_i, k);
                chk("bubble hold idx",     {23'd0, sample_idx}, k);
            end
        end
        chk("bubble frame_cnt", {16'd0, frame_cnt}, 32'd4);
        $display("bubble: 128 beats over bubbled input");
        chk_gap("bubble");

        // Reset in the middle of a frame
        for (int k = 0; k < 60; k++) begin
            drive(1'b1, k, 1'b0);
            tick();
            chk_beat("prereset", k, 1'b0, 1'b0, 1'b0);
        end
        drive(1'b0, 0, 1'b0);
        rstn = 1'b0;
        #1;
        chk_all_zero("midreset");
        tick();
        rstn = 1'b1;
        tick();
        chk("midreset no clr", {31'd0, search_clr}, 32'd0);
        chk("midreset data_en", {31'd0, data_en}, 32'd0);
        $display("midreset: partial frame discarded");

        // Back-to-back frames with s_valid held high
        for (int f = 0; f < 3; f++) begin
            for (int k = 0; k < 128; k++) begin
                drive(1'b1, k, k == 127);
                tick();
                chk_beat("b2b", k, k == 127, 1'b0, 1'b0);
                if (k == 0) chk("b2b clr at first beat", {31'd0, search_clr}, 32'd0);
            end
            chk("b2b frame_cnt", {16'd0, frame_cnt}, f + 1);
            if (f < 2) begin
                drive(1'b1, 0, 1'b0);
                stalls = 0;
                for (int t = 0; t < 10; t++) begin
                    if (s_ready) break;
                    tick();
                    stalls++;
                    chk("b2b gap data_en", {31'd0, data_en}, 32'd0);
                end
                chk("b2b stall count", stalls, 32'd2);
                chk("b2b clr before data", {31'd0, search_clr}, 32'd1);
                $display("b2b: frame %0d done, %0d stall cycles", f + 1, stalls);
            end
        end
        chk("b2b final frame_cnt", {16'd0, frame_cnt}, 32'd3);
        chk_gap("b2b");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
